// File: rtl/thermal_pkg.sv
// Shared thermal-plant definitions: actuator mode encoding and default plant constants.
// Pure declarations: no logic, no latency, no backpressure.
package thermal_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE     = 2'd0,
    MODE_HEAT     = 2'd1,
    MODE_COOL     = 2'd2,
    MODE_CONFLICT = 2'd3
  } mode_e;

  localparam int DEF_WIDTH     = 5;
  localparam int DEF_INIT_TEMP = 20;
  localparam int DEF_AMBIENT   = 18;
  localparam int DEF_T_MIN     = 0;
  localparam int DEF_T_MAX     = 31;

  function automatic mode_e decode_mode(input logic heating, input logic cooling);
    case ({heating, cooling})
      2'b10:   return MODE_HEAT;
      2'b01:   return MODE_COOL;
      2'b11:   return MODE_CONFLICT;
      default: return MODE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/rate_divider.sv
// Shared step-rate counter: counts 0..term while en, tick flags the terminal count.
// tick is a pure function of the stored count; clr dominates en; no backpressure.
module rate_divider #(
  parameter int DIV = 1,
  parameter int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] term,
  output logic          tick
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  always_comb begin
    tick  = (cnt_q == term);
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

endmodule

// File: rtl/room_thermal_model.sv
// Room thermal plant: heat/cool ramps, drift toward ambient, saturation, load override.
// All outputs registered (one-edge update); load beats enable; no backpressure.
module room_thermal_model
  import thermal_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int INIT_TEMP = DEF_INIT_TEMP,
  parameter int AMBIENT   = DEF_AMBIENT,
  parameter int HEAT_DIV  = 1,
  parameter int COOL_DIV  = 1,
  parameter int DRIFT_DIV = 8,
  parameter int T_MIN     = DEF_T_MIN,
  parameter int T_MAX     = DEF_T_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             heating,
  input  logic             cooling,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] temperature,
  output logic             temp_step,
  output logic             at_limit,
  output logic             fault
);

  localparam int HC_DIV  = (HEAT_DIV > COOL_DIV) ? HEAT_DIV : COOL_DIV;
  localparam int MAX_DIV = (HC_DIV > DRIFT_DIV) ? HC_DIV : DRIFT_DIV;
  localparam int CW      = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

  localparam logic [CW-1:0]    HEAT_TC  = CW'(HEAT_DIV - 1);
  localparam logic [CW-1:0]    COOL_TC  = CW'(COOL_DIV - 1);
  localparam logic [CW-1:0]    DRIFT_TC = CW'(DRIFT_DIV - 1);
  localparam logic [WIDTH:0]   MIN_X    = (WIDTH+1)'(T_MIN);
  localparam logic [WIDTH:0]   MAX_X    = (WIDTH+1)'(T_MAX);
  localparam logic [WIDTH-1:0] MIN_W    = WIDTH'(T_MIN);
  localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(T_MAX);
  localparam logic [WIDTH-1:0] AMB_W    = WIDTH'(AMBIENT);
  localparam logic [WIDTH-1:0] INIT_W   = WIDTH'(INIT_TEMP);
  localparam logic INIT_LIMIT = (INIT_TEMP == T_MIN) || (INIT_TEMP == T_MAX);

  mode_e            mode_q, mode_d, mode_in;
  logic [WIDTH-1:0] temp_q, temp_d;
  logic             step_q, step_d;
  logic             limit_q, limit_d;
  logic             fault_q, fault_d;

  logic             div_clr, div_en, div_tick;
  logic [CW-1:0]    div_term;
  logic [WIDTH:0]   temp_x, lv_x, load_x, up_x, dn_x, drift_x, next_x;
  logic             at_amb;

  rate_divider #(.DIV(MAX_DIV), .CW(CW)) u_rate_divider (
    .clk  (clk),
    .rst  (rst),
    .clr  (div_clr),
    .en   (div_en),
    .term (div_term),
    .tick (div_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_IDLE;
      temp_q  <= INIT_W;
      step_q  <= 1'b0;
      limit_q <= INIT_LIMIT;
      fault_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      temp_q  <= temp_d;
      step_q  <= step_d;
      limit_q <= limit_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    mode_in = decode_mode(heating, cooling);
    temp_x  = {1'b0, temp_q};
    lv_x    = {1'b0, load_value};
    // Extra headroom bit lets the saturation compares see past the bounds.
    load_x  = (lv_x >= MAX_X) ? MAX_X : ((lv_x <= MIN_X) ? MIN_X : lv_x);
    up_x    = (temp_x >= MAX_X) ? MAX_X : temp_x + 1'b1;
    dn_x    = (temp_x <= MIN_X) ? MIN_X : temp_x - 1'b1;
    at_amb  = (temp_q == AMB_W);
    drift_x = (temp_q > AMB_W) ? dn_x : up_x;

    case (mode_q)
      MODE_HEAT: div_term = HEAT_TC;
      MODE_COOL: div_term = COOL_TC;
      default:   div_term = DRIFT_TC;
    endcase

    mode_d  = mode_q;
    fault_d = fault_q;
    div_clr = 1'b0;
    div_en  = 1'b0;
    next_x  = temp_x;

    if (load) begin
      mode_d  = mode_in;
      fault_d = fault_q | (mode_in == MODE_CONFLICT);
      div_clr = 1'b1;
      next_x  = load_x;
    end else if (enable) begin
      mode_d  = mode_in;
      fault_d = fault_q | (mode_in == MODE_CONFLICT);
      // A mode change restarts the count and costs one edge before any step.
      if (mode_in != mode_q || mode_in == MODE_CONFLICT ||
          (mode_in == MODE_IDLE && at_amb)) begin
        div_clr = 1'b1;
      end else begin
        div_en = 1'b1;
        if (div_tick) begin
          case (mode_q)
            MODE_HEAT: next_x = up_x;
            MODE_COOL: next_x = dn_x;
            default:   next_x = drift_x;
          endcase
        end
      end
    end

    temp_d  = next_x[WIDTH-1:0];
    step_d  = (temp_d != temp_q);
    limit_d = (temp_d == MIN_W) || (temp_d == MAX_W);
  end

  always_comb begin
    temperature = temp_q;
    temp_step   = step_q;
    at_limit    = limit_q;
    fault       = fault_q;
  end

endmodule
